// File: rtl/VX_gpu_pkg.sv
// VX_gpu_pkg
// Shared constants for the dispatch path: ex_type width, number of execute
// units and performance counter width, plus a small wrap-around helper used
// by the round-robin arbiters.
// Ports: none (package).
package VX_gpu_pkg;

    localparam int EX_BITS       = 3;
    localparam int NUM_EX_UNITS  = 8;
    localparam int PERF_CTR_BITS = 44;

    // Index following idx in a ring of n entries.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/vx_dispatch_rr_lock.sv
// vx_dispatch_rr_lock
// Per-output arbiter. Unlocked it grants round-robin starting at rr_ptr;
// once a non-eop beat fires it locks onto that input until the input's eop
// beat fires, so multi-beat packets reach the unit contiguously.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   req            per-input request for this output
//   eop            per-input end-of-packet flag
//   accept         the output FIFO can take a beat this cycle
//   grant          one-hot grant (combinational, independent of accept)
module vx_dispatch_rr_lock
    import VX_gpu_pkg::*;
#(
    parameter int NUM_INPUTS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [NUM_INPUTS-1:0] eop,
    input  logic                  accept,
    output logic [NUM_INPUTS-1:0] grant
);

    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] lock_id;
    logic             locked;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    int               cand;

    // Scan from the farthest candidate back towards rr_ptr so the one
    // closest to rr_ptr is the last to overwrite the winner.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = 0;
        if (locked) begin
            win_idx   = lock_id;
            win_found = req[lock_id];
        end else begin
            for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                cand = (int'(rr_ptr) + k) % NUM_INPUTS;
                if (req[cand]) begin
                    win_idx   = IDX_W'(cand);
                    win_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (win_found) grant[win_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr  <= '0;
            lock_id <= '0;
            locked  <= 1'b0;
        end else if (win_found && accept) begin
            if (eop[win_idx]) begin
                locked <= 1'b0;
                rr_ptr <= IDX_W'(rr_next(int'(win_idx), NUM_INPUTS));
            end else begin
                locked  <= 1'b1;
                lock_id <= win_idx;
            end
        end
    end

endmodule

// File: rtl/vx_dispatch_router.sv
// vx_dispatch_router
// Routes operand beats from NUM_INPUTS issue slices to NUM_OUTPUTS execute
// units selected by ex_type. Each unit has a packet-locked round-robin
// arbiter and a BUF_SIZE-deep FIFO whose head drives out_valid/out_data.
// Beats with an out-of-range ex_type are accepted, dropped and flagged.
// Optional feature macro: VX_DISPATCH_PERF_EN adds perf_stalls/perf_instrs.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   in_valid/in_data/in_ex_type   per-slice beat, payload and destination
//   in_sop/in_eop                 packet delimiters (only eop is used)
//   in_ready                      beat accepted this cycle
//   out_valid/out_data/out_ready  per-unit FIFO head handshake
//   err_ex_type                   sticky bad-destination flag
//   perf_stalls/perf_instrs       per-unit counters (VX_DISPATCH_PERF_EN)
module vx_dispatch_router
    import VX_gpu_pkg::*;
#(
    parameter int NUM_INPUTS    = 2,
    parameter int NUM_OUTPUTS   = VX_gpu_pkg::NUM_EX_UNITS,
    parameter int DATAW         = 256,
    parameter int EX_BITS       = VX_gpu_pkg::EX_BITS,
    parameter int BUF_SIZE      = 2,
    parameter int PERF_CTR_BITS = VX_gpu_pkg::PERF_CTR_BITS
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_INPUTS-1:0]                  in_valid,
    input  logic [NUM_INPUTS-1:0][DATAW-1:0]       in_data,
    input  logic [NUM_INPUTS-1:0][EX_BITS-1:0]     in_ex_type,
    input  logic [NUM_INPUTS-1:0]                  in_sop,
    input  logic [NUM_INPUTS-1:0]                  in_eop,
    output logic [NUM_INPUTS-1:0]                  in_ready,
    output logic [NUM_OUTPUTS-1:0]                 out_valid,
    output logic [NUM_OUTPUTS-1:0][DATAW-1:0]      out_data,
    input  logic [NUM_OUTPUTS-1:0]                 out_ready,
    output logic                                   err_ex_type
`ifdef VX_DISPATCH_PERF_EN
    ,
    output logic [NUM_OUTPUTS-1:0][PERF_CTR_BITS-1:0] perf_stalls,
    output logic [NUM_OUTPUTS-1:0][PERF_CTR_BITS-1:0] perf_instrs
`endif
);

    localparam int ADDR_W = $clog2(BUF_SIZE);
    localparam int CNT_W  = $clog2(BUF_SIZE + 1);

    logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0] req;
    logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0] grant;
    logic [NUM_OUTPUTS-1:0]                 accept;
    logic [NUM_OUTPUTS-1:0]                 push;
    logic [NUM_OUTPUTS-1:0]                 pop;
    logic [NUM_INPUTS-1:0]                  bad_type;

    // sop carries no meaning for routing; only eop ends a lock.
    logic unused_sop;
    assign unused_sop = ^in_sop;

    // A valid beat that matches no unit is a bad destination.
    always_comb begin
        req      = '0;
        bad_type = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                req[j][i] = in_valid[i] && (in_ex_type[i] == EX_BITS'(j));
            end
        end
        for (int i = 0; i < NUM_INPUTS; i++) begin
            bad_type[i] = in_valid[i];
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                if (req[j][i]) bad_type[i] = 1'b0;
            end
        end
    end

    always_comb begin
        in_ready = bad_type;
        for (int j = 0; j < NUM_OUTPUTS; j++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (grant[j][i] && accept[j]) in_ready[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_ex_type <= 1'b0;
        end else if (|bad_type) begin
            err_ex_type <= 1'b1;
        end
    end

    for (genvar j = 0; j < NUM_OUTPUTS; j++) begin : g_out
        logic [DATAW-1:0]  mem [BUF_SIZE];
        logic [ADDR_W-1:0] rd_ptr;
        logic [ADDR_W-1:0] wr_ptr;
        logic [CNT_W-1:0]  count;
        logic [DATAW-1:0]  push_data;

        vx_dispatch_rr_lock #(
            .NUM_INPUTS (NUM_INPUTS)
        ) u_arb (
            .clk    (clk),
            .reset  (reset),
            .req    (req[j]),
            .eop    (in_eop),
            .accept (accept[j]),
            .grant  (grant[j])
        );

        // A full FIFO still accepts when its head leaves this cycle.
        assign accept[j] = (count != CNT_W'(BUF_SIZE)) || out_ready[j];
        assign push[j]   = (|grant[j]) && accept[j];
        assign pop[j]    = out_ready[j] && (count != '0);

        always_comb begin
            push_data = '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (grant[j][i]) push_data = push_data | in_data[i];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[j]) begin
                    wr_ptr <= (wr_ptr == ADDR_W'(BUF_SIZE - 1)) ? '0 : wr_ptr + 1'b1;
                end
                if (pop[j]) begin
                    rd_ptr <= (rd_ptr == ADDR_W'(BUF_SIZE - 1)) ? '0 : rd_ptr + 1'b1;
                end
                case ({push[j], pop[j]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        // Payload storage needs no reset; out_data is ignored while empty.
        always_ff @(posedge clk) begin
            if (push[j]) mem[wr_ptr] <= push_data;
        end

        assign out_valid[j] = (count != '0);
        assign out_data[j]  = mem[rd_ptr];
    end

`ifdef VX_DISPATCH_PERF_EN
    for (genvar j = 0; j < NUM_OUTPUTS; j++) begin : g_perf
        logic stall;
        logic instr;

        assign stall = |(req[j] & ~in_ready);
        assign instr = push[j] && (|(grant[j] & in_eop));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                perf_stalls[j] <= '0;
                perf_instrs[j] <= '0;
            end else begin
                if (stall) perf_stalls[j] <= perf_stalls[j] + 1'b1;
                if (instr) perf_instrs[j] <= perf_instrs[j] + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vx_dispatch_router.sv
module tb_vx_dispatch_router;

    localparam int NI  = 2;
    localparam int NO  = 6;
    localparam int DW  = 32;
    localparam int EXB = 3;
    localparam int BUF = 2;
    localparam int PCB = 44;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NI-1:0]           in_valid;
    logic [NI-1:0][DW-1:0]   in_data;
    logic [NI-1:0][EXB-1:0]  in_ex_type;
    logic [NI-1:0]           in_sop;
    logic [NI-1:0]           in_eop;
    logic [NI-1:0]           in_ready;
    logic [NO-1:0]           out_valid;
    logic [NO-1:0][DW-1:0]   out_data;
    logic [NO-1:0]           out_ready;
    logic                    err_ex_type;
`ifdef VX_DISPATCH_PERF_EN
    logic [NO-1:0][PCB-1:0]  perf_stalls;
    logic [NO-1:0][PCB-1:0]  perf_instrs;
`endif

    vx_dispatch_router #(
        .NUM_INPUTS    (NI),
        .NUM_OUTPUTS   (NO),
        .DATAW         (DW),
        .EX_BITS       (EXB),
        .BUF_SIZE      (BUF),
        .PERF_CTR_BITS (PCB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ex_type  (in_ex_type),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .err_ex_type (err_ex_type)
`ifdef VX_DISPATCH_PERF_EN
        ,
        .perf_stalls (perf_stalls),
        .perf_instrs (perf_instrs)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: per-unit queues, who last finished a packet, who holds
    // a packet open. Updated at the falling edge using the inputs that the
    // next rising edge will see.
    logic [DW-1:0] mq [NO][$];
    int            m_next [NO];
    bit            m_open [NO];
    int            m_owner [NO];
    bit            m_err;

    function automatic bit wants(input int i, input int j);
        return in_valid[i] && (int'(in_ex_type[i]) == j);
    endfunction

    always @(negedge clk) begin
        int            win [NO];
        int            c;
        logic [NI-1:0] exp_rdy;
        if (reset) begin
            for (int j = 0; j < NO; j++) begin
                mq[j].delete();
                m_next[j]  = 0;
                m_open[j]  = 0;
                m_owner[j] = 0;
            end
            m_err = 0;
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_err", 64'(err_ex_type), 64'd0);
        end else begin
            exp_rdy = '0;
            for (int j = 0; j < NO; j++) begin
                win[j] = -1;
                if (m_open[j]) begin
                    if (wants(m_owner[j], j)) win[j] = m_owner[j];
                end else begin
                    for (int k = 0; k < NI; k++) begin
                        c = (m_next[j] + k) % NI;
                        if (win[j] < 0 && wants(c, j)) win[j] = c;
                    end
                end
                if (win[j] >= 0 && !(mq[j].size() < BUF || out_ready[j])) win[j] = -1;
                if (win[j] >= 0) exp_rdy[win[j]] = 1'b1;
            end
            for (int i = 0; i < NI; i++) begin
                if (in_valid[i] && int'(in_ex_type[i]) >= NO) exp_rdy[i] = 1'b1;
            end
            check("m_in_ready", 64'(in_ready), 64'(exp_rdy));
            for (int j = 0; j < NO; j++) begin
                check("m_out_valid", 64'(out_valid[j]), 64'(mq[j].size() > 0));
                if (mq[j].size() > 0) check("m_out_data", 64'(out_data[j]), 64'(mq[j][0]));
            end
            check("m_err", 64'(err_ex_type), 64'(m_err));
            for (int j = 0; j < NO; j++) begin
                if (out_ready[j] && mq[j].size() > 0) void'(mq[j].pop_front());
                if (win[j] >= 0) begin
                    mq[j].push_back(in_data[win[j]]);
                    if (in_eop[win[j]]) begin
                        m_open[j] = 0;
                        m_next[j] = (win[j] + 1) % NI;
                    end else begin
                        m_open[j]  = 1;
                        m_owner[j] = win[j];
                    end
                end
            end
            for (int i = 0; i < NI; i++) begin
                if (in_valid[i] && int'(in_ex_type[i]) >= NO) m_err = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = '0;
        in_sop   = '0;
        in_eop   = '0;
    endtask

    task automatic beat(input int i, input int ex, input bit sop, input bit eop, input logic [DW-1:0] d);
        in_valid[i]   = 1'b1;
        in_ex_type[i] = EXB'(ex);
        in_sop[i]     = sop;
        in_eop[i]     = eop;
        in_data[i]    = d;
    endtask

    logic [1:0]    seq2 [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0]    seq3 [4] = '{2'b10, 2'b10, 2'b10, 2'b01};
    logic [1:0]    seq4 [6] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01};
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;

    initial begin
        reset      = 1'b1;
        idle();
        in_data    = '0;
        in_ex_type = '0;
        out_ready  = '1;
        repeat (2) tick();
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_err", 64'(err_ex_type), 64'd0);
        reset = 1'b0;

        // single beat to unit 3
        beat(0, 3, 1'b1, 1'b1, 32'hA5A5_0003);
        #1 check("t1_ready", 64'(in_ready), 64'b01);
        tick();
        idle();
        #1;
        check("t1_valid", 64'(out_valid), 64'b001000);
        check("t1_data", 64'(out_data[3]), 64'hA5A5_0003);
        tick();
        check("t1_drain", 64'(out_valid), 64'd0);

        // both slices contend for unit 2 with single-beat packets
        d0 = 32'h2000_0000;
        d1 = 32'h2100_0000;
        for (int c = 0; c < 4; c++) begin
            beat(0, 2, 1'b1, 1'b1, d0);
            beat(1, 2, 1'b1, 1'b1, d1);
            #1 check("t2_alternate", 64'(in_ready), 64'(seq2[c]));
            if (in_ready[0]) d0 = d0 + 1;
            if (in_ready[1]) d1 = d1 + 1;
            tick();
        end
        idle();
        repeat (3) tick();

        // slice 1 holds unit 5 for a 3-beat packet while slice 0 waits
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: beat(1, 5, 1'b1, 1'b0, 32'h5100_0000);
                1: begin
                    beat(1, 5, 1'b0, 1'b0, 32'h5100_0001);
                    beat(0, 5, 1'b1, 1'b1, 32'h5000_0000);
                end
                2: beat(1, 5, 1'b0, 1'b1, 32'h5100_0002);
                default: in_valid[1] = 1'b0;
            endcase
            #1 check("t3_lock", 64'(in_ready), 64'(seq3[c]));
            if (c == 1) check("t3_first_beat", 64'(out_data[5]), 64'h5100_0000);
            tick();
        end
        idle();
        repeat (3) tick();

        // unit 1 backpressured, then released
        out_ready[1] = 1'b0;
        d0 = 32'h1000_0000;
        for (int c = 0; c < 6; c++) begin
            if (c == 4) out_ready[1] = 1'b1;
            beat(0, 1, 1'b1, 1'b1, d0);
            #1 check("t4_backpressure", 64'(in_ready), 64'(seq4[c]));
            if (c == 2) check("t4_head0", 64'(out_data[1]), 64'h1000_0000);
            if (c == 5) check("t4_head1", 64'(out_data[1]), 64'h1000_0001);
            if (in_ready[0]) d0 = d0 + 1;
            tick();
        end
        idle();
        repeat (4) tick();

        // out-of-range destination
        beat(1, 7, 1'b1, 1'b1, 32'hDEAD_0007);
        #1 check("t5_ready", 64'(in_ready), 64'b10);
        tick();
        idle();
        #1;
        check("t5_err", 64'(err_ex_type), 64'd1);
        check("t5_no_valid", 64'(out_valid), 64'd0);
        repeat (3) tick();
        check("t5_err_sticky", 64'(err_ex_type), 64'd1);

        // reset with a packet open on unit 4 and data parked in units 3/4
        out_ready[3] = 1'b0;
        out_ready[4] = 1'b0;
        beat(0, 4, 1'b1, 1'b0, 32'h4000_0000);
        beat(1, 3, 1'b1, 1'b1, 32'h3100_0000);
        #1 check("t6_both_fire", 64'(in_ready), 64'b11);
        tick();
        in_valid[1] = 1'b0;
        beat(0, 4, 1'b0, 1'b0, 32'h4000_0001);
        #1 check("t6_parked", 64'(out_valid), 64'b011000);
        reset = 1'b1;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_err", 64'(err_ex_type), 64'd0);
        tick();
        reset = 1'b0;
        idle();
        out_ready = '1;
`ifdef VX_DISPATCH_PERF_EN
        #1;
        check("t6_perf_stalls", 64'(perf_stalls[4]), 64'd0);
        check("t6_perf_instrs", 64'(perf_instrs[3]), 64'd0);
`endif
        beat(1, 4, 1'b1, 1'b1, 32'h4100_0000);
        #1 check("t6_unlocked", 64'(in_ready), 64'b10);
        tick();
        beat(0, 4, 1'b1, 1'b1, 32'h4000_0002);
        beat(1, 4, 1'b1, 1'b1, 32'h4100_0001);
        #1 check("t6_rr_after_reset", 64'(in_ready), 64'b01);
        tick();
        idle();
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
